// File: rtl/clk_enable_synth_pkg.sv
// Shared types and helpers for the fractional clock-enable synthesiser.
package clk_enable_synth_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSettling,
    StLocked
  } chan_state_t;

  localparam int unsigned AccWDefault = 16;

  function automatic int unsigned ch_idx_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_enable_synth_channel.sv
// One enable channel: phase accumulator, lock counter and state.
// CLK_ENABLE_SYNTH_GATE_EN masks strobes until the channel has locked.
module clk_enable_channel
  import clk_enable_synth_pkg::*;
#(
  parameter int unsigned ACC_W       = AccWDefault,
  parameter int unsigned LOCK_CYCLES = 16
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic             idle_i,
  input  logic [ACC_W-1:0] mult_i,
  input  logic [ACC_W-1:0] div_i,
  output logic             ce_o,
  output logic             locked_o,
  output chan_state_t      state_o
);

  localparam int unsigned CntW = $clog2(LOCK_CYCLES);

  chan_state_t      state_d, state_q;
  logic [ACC_W:0]   acc_d, acc_q, sum;
  logic [ACC_W-1:0] mult_d, mult_q, div_d, div_q;
  logic [CntW-1:0]  cnt_d, cnt_q;
  logic             ce_d, ce_q, locked_d, locked_q;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mult_d   = mult_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    ce_d     = 1'b0;
    locked_d = locked_q;
    sum      = acc_q + {1'b0, mult_q};
    if (idle_i) begin
      state_d  = StIdle;
      acc_d    = '0;
      mult_d   = '0;
      div_d    = '0;
      cnt_d    = '0;
      locked_d = 1'b0;
    end else if (load_i) begin
      state_d  = StSettling;
      acc_d    = '0;
      mult_d   = mult_i;
      div_d    = div_i;
      cnt_d    = '0;
      locked_d = 1'b0;
    end else if (state_q != StIdle) begin
      // acc stays below div, so one subtraction restores the invariant
      if (sum >= {1'b0, div_q}) begin
        acc_d = sum - {1'b0, div_q};
        ce_d  = 1'b1;
      end else begin
        acc_d = sum;
      end
      if (state_q == StSettling) begin
        if (cnt_q == CntW'(LOCK_CYCLES - 1)) begin
          state_d  = StLocked;
          locked_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      mult_q   <= '0;
      div_q    <= '0;
      cnt_q    <= '0;
      ce_q     <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mult_q   <= mult_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      ce_q     <= ce_d;
      locked_q <= locked_d;
    end
  end

`ifdef CLK_ENABLE_SYNTH_GATE_EN
  assign ce_o = ce_q & locked_q;
`else
  assign ce_o = ce_q;
`endif
  assign locked_o = locked_q;
  assign state_o  = state_q;

endmodule

// File: rtl/clk_enable_synth.sv
// Multi-channel fractional clock-enable synthesiser with valid/ready config port.
// Optional strobe gating until lock: CLK_ENABLE_SYNTH_GATE_EN (see channel).
module clk_enable_synth
  import clk_enable_synth_pkg::*;
#(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned ACC_W       = AccWDefault,
  parameter int unsigned LOCK_CYCLES = 16
) (
  input  logic                          clock_in,
  input  logic                          reset_n,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [ch_idx_w(NUM_CH)-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]              cfg_mult,
  input  logic [ACC_W-1:0]              cfg_div,
  output logic                          cfg_err,
  output logic [NUM_CH-1:0]             ce_out,
  output logic [NUM_CH-1:0]             locked,
  output logic                          all_locked
);

  logic              accept, ch_bad, ratio_bad, go_idle, go_load;
  logic [31:0]       ch_ext;
  logic              cfg_ready_d, cfg_ready_q, cfg_err_d, cfg_err_q;
  logic [NUM_CH-1:0] load, idle, settling, active;

  always_comb begin
    ch_ext      = 32'(cfg_ch);
    accept      = cfg_valid && cfg_ready_q;
    ch_bad      = ch_ext >= NUM_CH;
    ratio_bad   = (cfg_div == '0) || (cfg_mult > cfg_div);
    go_idle     = accept && !ch_bad && (ratio_bad || (cfg_mult == '0));
    go_load     = accept && !ch_bad && !ratio_bad && (cfg_mult != '0);
    cfg_err_d   = accept && (ch_bad || ratio_bad);
    // Only one channel may settle at a time
    cfg_ready_d = !go_load && !(|settling);
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      cfg_ready_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      cfg_ready_q <= cfg_ready_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    chan_state_t state;

    assign load[i] = go_load && (ch_ext == 32'(i));
    assign idle[i] = go_idle && (ch_ext == 32'(i));

    clk_enable_channel #(
      .ACC_W       (ACC_W),
      .LOCK_CYCLES (LOCK_CYCLES)
    ) u_chan (
      .clock_in (clock_in),
      .reset_n  (reset_n),
      .load_i   (load[i]),
      .idle_i   (idle[i]),
      .mult_i   (cfg_mult),
      .div_i    (cfg_div),
      .ce_o     (ce_out[i]),
      .locked_o (locked[i]),
      .state_o  (state)
    );

    assign settling[i] = (state == StSettling);
    assign active[i]   = (state != StIdle);
  end

  assign cfg_ready  = cfg_ready_q;
  assign cfg_err    = cfg_err_q;
  assign all_locked = (|active) && (&(locked | ~active));

endmodule

// File: tb/tb_clk_enable_synth.sv
// Scoreboard bench: stimulus pushes hand-derived per-cycle expectations, a monitor checks them.
module tb_clk_enable_synth;

  localparam int NumCh = 3;
  localparam int Lock  = 16;
  localparam int Big   = 1 << 29;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] val;
  } exp_t;

  logic        clock_in, reset_n, cfg_valid, cfg_ready, cfg_err, all_locked;
  logic [1:0]  cfg_ch;
  logic [15:0] cfg_mult, cfg_div;
  logic [2:0]  ce_out, locked;

  exp_t q[$];
  int   err_cyc[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errs = 0;
  int   ch0_start = Big, ch0_end = Big, ch0_per = 4;
  int   ch1_start = Big;

  clk_enable_synth #(
    .NUM_CH      (NumCh),
    .ACC_W       (16),
    .LOCK_CYCLES (Lock)
  ) dut (
    .clock_in   (clock_in),
    .reset_n    (reset_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_mult   (cfg_mult),
    .cfg_div    (cfg_div),
    .cfg_err    (cfg_err),
    .ce_out     (ce_out),
    .locked     (locked),
    .all_locked (all_locked)
  );

  initial begin
    clock_in = 1'b0;
    forever #5 clock_in = ~clock_in;
  end

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic string sig_name(int sig);
    case (sig)
      0:       return "ce_out";
      1:       return "locked";
      2:       return "cfg_ready";
      3:       return "cfg_err";
      default: return "all_locked";
    endcase
  endfunction

  function automatic logic [31:0] actual(int sig);
    case (sig)
      0:       return 32'(ce_out);
      1:       return 32'(locked);
      2:       return 32'(cfg_ready);
      3:       return 32'(cfg_err);
      default: return 32'(all_locked);
    endcase
  endfunction

  // Hand-derived patterns: 1/N strobes every N edges, 3/7 strobes at phases 3, 5, 0 mod 7
  function automatic logic strobe0(int c);
    if (!(c > ch0_start && c < ch0_end)) return 1'b0;
    if ((c - ch0_start) % ch0_per != 0) return 1'b0;
`ifdef CLK_ENABLE_SYNTH_GATE_EN
    if (c < ch0_start + Lock) return 1'b0;
`endif
    return 1'b1;
  endfunction

  function automatic logic strobe1(int c);
    int m;
    if (!(c > ch1_start)) return 1'b0;
    m = (c - ch1_start) % 7;
`ifdef CLK_ENABLE_SYNTH_GATE_EN
    if (c < ch1_start + Lock) return 1'b0;
`endif
    return (m == 0) || (m == 3) || (m == 5);
  endfunction

  function automatic logic err_at(int c);
    foreach (err_cyc[i]) if (err_cyc[i] == c) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void push_window(int c0, int c1);
    logic a0, a1, l0, l1, rdy;
    for (int c = c0; c <= c1; c++) begin
      a0  = (c >= ch0_start) && (c < ch0_end);
      a1  = (c >= ch1_start);
      l0  = a0 && (c >= ch0_start + Lock);
      l1  = a1 && (c >= ch1_start + Lock);
      rdy = !((a0 && c <= ch0_start + Lock) || (a1 && c <= ch1_start + Lock));
      q.push_back('{c, 0, {29'd0, 1'b0, strobe1(c), strobe0(c)}});
      q.push_back('{c, 1, {29'd0, 1'b0, l1, l0}});
      q.push_back('{c, 2, {31'd0, rdy}});
      q.push_back('{c, 3, {31'd0, err_at(c)}});
      q.push_back('{c, 4, {31'd0, (a0 || a1) && (l0 || !a0) && (l1 || !a1)}});
    end
  endfunction

  function automatic void push_zero(int c);
    for (int s = 0; s < 5; s++) q.push_back('{c, s, 32'd0});
  endfunction

  task automatic wait_cyc(int n);
    while (cyc < n) @(negedge clock_in);
  endtask

  task automatic start_cfg(int ch, int m, int d, output int acc);
    cfg_valid = 1'b1;
    cfg_ch    = 2'(ch);
    cfg_mult  = 16'(m);
    cfg_div   = 16'(d);
    acc       = cyc + 1;
  endtask

  task automatic run(int a, int len);
    push_window(a, a + len);
    wait_cyc(a);
    cfg_valid = 1'b0;
    wait_cyc(a + len);
  endtask

  // Monitor
  initial begin
    forever begin
      @(posedge clock_in);
      #1;
      cyc++;
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].cyc == cyc) begin
          check($sformatf("%s@%0d", sig_name(q[i].sig), cyc), actual(q[i].sig), q[i].val);
          q.delete(i);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, r;
    reset_n   = 1'b0;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_mult  = '0;
    cfg_div   = '0;
    for (int c = 1; c <= 3; c++) push_zero(c);
    wait_cyc(3);
    reset_n = 1'b1;
    push_window(4, 14);
    wait_cyc(14);

    start_cfg(0, 1, 4, a); ch0_start = a; ch0_per = 4; run(a, 40);
    start_cfg(1, 3, 7, a); ch1_start = a; run(a, 700);

    start_cfg(2, 1, 0, a); err_cyc.push_back(a); run(a, 3);
    start_cfg(2, 5, 4, a); err_cyc.push_back(a); run(a, 3);
    start_cfg(3, 1, 2, a); err_cyc.push_back(a); run(a, 3);

    start_cfg(0, 1, 2, a); ch0_start = a; ch0_per = 2; run(a, 30);
    start_cfg(0, 0, 5, a); ch0_end = a; run(a, 10);

    start_cfg(0, 1, 4, a); ch0_start = a; ch0_per = 4; ch0_end = Big; run(a, 5);
    #1 reset_n = 1'b0;
    #1;
    check("async_ce_out", 32'(ce_out), 32'd0);
    check("async_locked", 32'(locked), 32'd0);
    check("async_cfg_ready", 32'(cfg_ready), 32'd0);
    check("async_all_locked", 32'(all_locked), 32'd0);
    r = cyc;
    for (int c = r + 1; c <= r + 3; c++) push_zero(c);
    ch0_start = Big;
    ch1_start = Big;
    wait_cyc(r + 3);
    reset_n = 1'b1;
    r = cyc;
    push_window(r + 1, r + 20);
    wait_cyc(r + 22);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
